// File: rtl/pipeline_mem_stage6_pkg.sv
// Shared types and widths for the memory-access stage: access encodings, FSM states,
// and the MEM/WB boundary payload.
package pipeline_mem_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [CTRL_W-1:0] {
        RD_NONE = 3'd0,
        RD_LB   = 3'd1,
        RD_LBU  = 3'd2,
        RD_LH   = 3'd3,
        RD_LHU  = 3'd4,
        RD_LW   = 3'd5,
        RD_LWU  = 3'd6,
        RD_LD   = 3'd7
    } dm_rd_ctrl_e;

    // Codes 5-7 are left unnamed and decode as "no store".
    typedef enum logic [CTRL_W-1:0] {
        WR_NONE = 3'd0,
        WR_SB   = 3'd1,
        WR_SH   = 3'd2,
        WR_SW   = 3'd3,
        WR_SD   = 3'd4
    } dm_wr_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } acc_size_e;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic             rf_wr_en;
        logic [SEL_W-1:0] rf_wr_sel;
        logic [XLEN-1:0]  alu_result;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  rdata;
        logic             misalign;
    } mem_wb_t;

    // Sign- or zero-extend the low field of v selected by sz.
    function automatic logic [XLEN-1:0] ext_field(input logic [XLEN-1:0] v,
                                                  input acc_size_e sz,
                                                  input logic sgn);
        logic [XLEN-1:0] r;
        case (sz)
            SZ_B:    r = {{(XLEN-8){sgn & v[7]}}, v[7:0]};
            SZ_H:    r = {{(XLEN-16){sgn & v[15]}}, v[15:0]};
            SZ_W:    r = {{(XLEN-32){sgn & v[31]}}, v[31:0]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipeline_mem_stage6_if.sv
// Valid/ready data-memory port between the MEM stage (master) and data memory (slave).
interface pipeline_mem_stage6_if;
    import pipeline_mem_pkg::*;

    logic              dmem_valid;
    logic              dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [STRB_W-1:0] dmem_wstrb;
    logic              dmem_ready;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ready, dmem_rdata
    );

endinterface

// File: rtl/pipeline_mem_stage6_align.sv
// Combinational byte-lane logic: store strobes/replication, load extraction/extension,
// and alignment check. A store wins when both controls are nonzero.
module mem_align_unit
    import pipeline_mem_pkg::*;
(
    input  logic [OFF_W-1:0]  i_off,
    input  logic [CTRL_W-1:0] i_rd_ctrl,
    input  logic [CTRL_W-1:0] i_wr_ctrl,
    input  logic [XLEN-1:0]   i_st_data,
    input  logic [XLEN-1:0]   i_ld_word,
    output logic              o_is_load,
    output logic              o_is_store,
    output logic              o_misalign,
    output logic [XLEN-1:0]   o_wdata,
    output logic [STRB_W-1:0] o_wstrb,
    output logic [XLEN-1:0]   o_ld_data
);

    acc_size_e         w_size;
    logic              w_sgn;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_bad_off;
    logic [STRB_W-1:0] w_strb;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_shift;

    // Decode access kind and size.
    always_comb begin
        w_is_store = 1'b0;
        w_is_load  = 1'b0;
        w_size     = SZ_B;
        w_sgn      = 1'b0;
        case (dm_wr_ctrl_e'(i_wr_ctrl))
            WR_SB:   begin w_is_store = 1'b1; w_size = SZ_B; end
            WR_SH:   begin w_is_store = 1'b1; w_size = SZ_H; end
            WR_SW:   begin w_is_store = 1'b1; w_size = SZ_W; end
            WR_SD:   begin w_is_store = 1'b1; w_size = SZ_D; end
            default: ;
        endcase
        if (!w_is_store) begin
            case (dm_rd_ctrl_e'(i_rd_ctrl))
                RD_LB:   begin w_is_load = 1'b1; w_size = SZ_B; w_sgn = 1'b1; end
                RD_LBU:  begin w_is_load = 1'b1; w_size = SZ_B; end
                RD_LH:   begin w_is_load = 1'b1; w_size = SZ_H; w_sgn = 1'b1; end
                RD_LHU:  begin w_is_load = 1'b1; w_size = SZ_H; end
                RD_LW:   begin w_is_load = 1'b1; w_size = SZ_W; w_sgn = 1'b1; end
                RD_LWU:  begin w_is_load = 1'b1; w_size = SZ_W; end
                RD_LD:   begin w_is_load = 1'b1; w_size = SZ_D; end
                default: ;
            endcase
        end
    end

    // Lane placement and alignment by size.
    always_comb begin
        w_bad_off = 1'b0;
        w_strb    = '0;
        w_wdata   = '0;
        case (w_size)
            SZ_B: begin
                w_strb  = STRB_W'(8'h01) << i_off;
                w_wdata = {8{i_st_data[7:0]}};
            end
            SZ_H: begin
                w_bad_off = i_off[0];
                w_strb    = STRB_W'(8'h03) << i_off;
                w_wdata   = {4{i_st_data[15:0]}};
            end
            SZ_W: begin
                w_bad_off = |i_off[1:0];
                w_strb    = STRB_W'(8'h0F) << i_off;
                w_wdata   = {2{i_st_data[31:0]}};
            end
            default: begin
                w_bad_off = |i_off;
                w_strb    = '1;
                w_wdata   = i_st_data;
            end
        endcase
    end

    assign w_shift    = i_ld_word >> {i_off, 3'b000};
    assign o_is_load  = w_is_load;
    assign o_is_store = w_is_store;
    assign o_misalign = (w_is_load | w_is_store) & w_bad_off;
    assign o_wdata    = w_wdata;
    assign o_wstrb    = w_is_store ? w_strb : '0;
    assign o_ld_data  = w_is_load ? ext_field(w_shift, w_size, w_sgn) : '0;

endmodule

// File: rtl/pipeline_mem_stage6.sv
// Memory-access stage: issues valid/ready data-memory requests, stalls upstream while an
// access is outstanding, and registers results into the MEM/WB boundary.
module pipeline_mem_stage6
    import pipeline_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [XLEN-1:0]   pc_EXA,
    input  logic              rf_wr_en_EXA,
    input  logic [SEL_W-1:0]  rf_wr_sel_EXA,
    input  logic [XLEN-1:0]   alu_result_EXA,
    input  logic [CTRL_W-1:0] dm_rd_ctrl_EXA,
    input  logic [CTRL_W-1:0] dm_wr_ctrl_EXA,
    input  logic [XLEN-1:0]   reg_data2_EXA,
    input  logic [REG_W-1:0]  rd_EXA,
    pipeline_mem_stage6_if.master dmem,
    output logic              stall_req,
    output logic [XLEN-1:0]   pc_MEM,
    output logic              rf_wr_en_MEM,
    output logic [SEL_W-1:0]  rf_wr_sel_MEM,
    output logic [XLEN-1:0]   alu_result_MEM,
    output logic [REG_W-1:0]  rd_MEM,
    output logic [XLEN-1:0]   dm_rdata_MEM,
    output logic              misalign_MEM
);

    mem_state_e      r_state;
    mem_state_e      w_state_nxt;
    mem_wb_t         r_mw;
    logic [XLEN-1:0] r_rdata_buf;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_misalign;
    logic              w_go;
    logic              w_valid;
    logic              w_stall_req;
    logic              w_done;
    logic [XLEN-1:0]   w_wdata;
    logic [STRB_W-1:0] w_wstrb;
    logic [XLEN-1:0]   w_ld_data;
    logic [XLEN-1:0]   w_ld_live;

    mem_align_unit u_align (
        .i_off      (alu_result_EXA[OFF_W-1:0]),
        .i_rd_ctrl  (dm_rd_ctrl_EXA),
        .i_wr_ctrl  (dm_wr_ctrl_EXA),
        .i_st_data  (reg_data2_EXA),
        .i_ld_word  (dmem.dmem_rdata),
        .o_is_load  (w_is_load),
        .o_is_store (w_is_store),
        .o_misalign (w_misalign),
        .o_wdata    (w_wdata),
        .o_wstrb    (w_wstrb),
        .o_ld_data  (w_ld_data)
    );

    assign w_go      = (w_is_load | w_is_store) & ~w_misalign;
    assign w_ld_live = (w_is_load & ~w_misalign) ? w_ld_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and bus/stall control; stall_req drops in the cycle ready arrives.
    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_stall_req = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    w_valid = 1'b1;
                    if (dmem.dmem_ready) begin
                        w_done = 1'b1;
                        if (stall) w_state_nxt = HOLD;
                    end else begin
                        w_stall_req = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                w_valid = 1'b1;
                if (dmem.dmem_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = stall ? HOLD : IDLE;
                end else begin
                    w_stall_req = 1'b1;
                end
            end
            HOLD: begin
                if (!stall) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Completed load data parked while the pipeline is frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata_buf <= '0;
        end else if (w_done && stall) begin
            r_rdata_buf <= w_ld_live;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mw <= '0;
        end else if (!stall) begin
            if (w_stall_req) begin
                r_mw <= '0;
            end else begin
                r_mw.pc         <= pc_EXA;
                r_mw.rf_wr_en   <= rf_wr_en_EXA & ~w_misalign;
                r_mw.rf_wr_sel  <= rf_wr_sel_EXA;
                r_mw.alu_result <= alu_result_EXA;
                r_mw.rd         <= rd_EXA;
                r_mw.rdata      <= (r_state == HOLD) ? r_rdata_buf : w_ld_live;
                r_mw.misalign   <= w_misalign;
            end
        end
    end

    // Request is dropped the instant reset asserts.
    assign dmem.dmem_valid = w_valid & reset;
    assign dmem.dmem_we    = w_is_store;
    assign dmem.dmem_addr  = {alu_result_EXA[XLEN-1:OFF_W], OFF_W'(0)};
    assign dmem.dmem_wdata = w_wdata;
    assign dmem.dmem_wstrb = w_wstrb;
    assign stall_req       = w_stall_req & reset;

    assign pc_MEM         = r_mw.pc;
    assign rf_wr_en_MEM   = r_mw.rf_wr_en;
    assign rf_wr_sel_MEM  = r_mw.rf_wr_sel;
    assign alu_result_MEM = r_mw.alu_result;
    assign rd_MEM         = r_mw.rd;
    assign dm_rdata_MEM   = r_mw.rdata;
    assign misalign_MEM   = r_mw.misalign;

endmodule

// File: tb/tb_pipeline_mem_stage6.sv
// Directed bench for the memory-access stage: stores, loads, wait states, misalignment,
// stall-held completion and asynchronous reset.
module tb_pipeline_mem_stage6;
    import pipeline_mem_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic [XLEN-1:0]   pc_EXA;
    logic              rf_wr_en_EXA;
    logic [SEL_W-1:0]  rf_wr_sel_EXA;
    logic [XLEN-1:0]   alu_result_EXA;
    logic [CTRL_W-1:0] dm_rd_ctrl_EXA;
    logic [CTRL_W-1:0] dm_wr_ctrl_EXA;
    logic [XLEN-1:0]   reg_data2_EXA;
    logic [REG_W-1:0]  rd_EXA;
    logic              stall_req;
    logic [XLEN-1:0]   pc_MEM;
    logic              rf_wr_en_MEM;
    logic [SEL_W-1:0]  rf_wr_sel_MEM;
    logic [XLEN-1:0]   alu_result_MEM;
    logic [REG_W-1:0]  rd_MEM;
    logic [XLEN-1:0]   dm_rdata_MEM;
    logic              misalign_MEM;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;

    pipeline_mem_stage6_if dmem_bus ();

    pipeline_mem_stage6 dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .pc_EXA         (pc_EXA),
        .rf_wr_en_EXA   (rf_wr_en_EXA),
        .rf_wr_sel_EXA  (rf_wr_sel_EXA),
        .alu_result_EXA (alu_result_EXA),
        .dm_rd_ctrl_EXA (dm_rd_ctrl_EXA),
        .dm_wr_ctrl_EXA (dm_wr_ctrl_EXA),
        .reg_data2_EXA  (reg_data2_EXA),
        .rd_EXA         (rd_EXA),
        .dmem           (dmem_bus),
        .stall_req      (stall_req),
        .pc_MEM         (pc_MEM),
        .rf_wr_en_MEM   (rf_wr_en_MEM),
        .rf_wr_sel_MEM  (rf_wr_sel_MEM),
        .alu_result_MEM (alu_result_MEM),
        .rd_MEM         (rd_MEM),
        .dm_rdata_MEM   (dm_rdata_MEM),
        .misalign_MEM   (misalign_MEM)
    );

    always #5 clk = ~clk;

    // Count writes the memory actually accepts.
    always @(posedge clk) begin
        if (dmem_bus.dmem_valid && dmem_bus.dmem_ready && dmem_bus.dmem_we)
            wr_cnt <= wr_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [63:0] pc, input logic rf_en, input logic [1:0] sel,
                          input logic [63:0] alu, input logic [2:0] rdc, input logic [2:0] wrc,
                          input logic [63:0] data, input logic [4:0] rd);
        pc_EXA         = pc;
        rf_wr_en_EXA   = rf_en;
        rf_wr_sel_EXA  = sel;
        alu_result_EXA = alu;
        dm_rd_ctrl_EXA = rdc;
        dm_wr_ctrl_EXA = wrc;
        reg_data2_EXA  = data;
        rd_EXA         = rd;
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        set_op(64'h0, 1'b0, 2'd0, 64'h0, 3'd0, 3'd0, 64'h0, 5'd0);
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = '0;
        #12;
        chk_eq("rst_pc_MEM", pc_MEM, 64'h0);
        chk_eq("rst_rf_wr_en_MEM", 64'(rf_wr_en_MEM), 64'h0);
        chk_eq("rst_alu_MEM", alu_result_MEM, 64'h0);
        chk_eq("rst_rdata_MEM", dm_rdata_MEM, 64'h0);
        chk_eq("rst_misalign_MEM", 64'(misalign_MEM), 64'h0);
        chk_eq("rst_valid", 64'(dmem_bus.dmem_valid), 64'h0);
        tick();
        reset = 1'b1;

        // SD, zero-wait
        set_op(64'h100, 1'b0, 2'd0, 64'h1000, 3'd0, 3'd4, 64'h1122334455667788, 5'd0);
        dmem_bus.dmem_ready = 1'b1;
        #1;
        chk_eq("sd_valid", 64'(dmem_bus.dmem_valid), 64'h1);
        chk_eq("sd_we", 64'(dmem_bus.dmem_we), 64'h1);
        chk_eq("sd_addr", dmem_bus.dmem_addr, 64'h1000);
        chk_eq("sd_wstrb", 64'(dmem_bus.dmem_wstrb), 64'hFF);
        chk_eq("sd_wdata", dmem_bus.dmem_wdata, 64'h1122334455667788);
        chk_eq("sd_stall_req", 64'(stall_req), 64'h0);
        tick();
        chk_eq("sd_pc_MEM", pc_MEM, 64'h100);
        chk_eq("sd_alu_MEM", alu_result_MEM, 64'h1000);
        chk_eq("sd_writes", 64'(wr_cnt), 64'd1);
        set_op(64'h104, 1'b0, 2'd0, 64'h0, 3'd0, 3'd0, 64'h0, 5'd0);
        dmem_bus.dmem_ready = 1'b0;
        #1;
        chk_eq("nop_valid", 64'(dmem_bus.dmem_valid), 64'h0);
        tick();
        chk_eq("sd_no_reissue", 64'(wr_cnt), 64'd1);

        // LB / LBU at byte offset 3
        set_op(64'h108, 1'b1, 2'd1, 64'h1003, 3'd1, 3'd0, 64'h0, 5'd5);
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 64'h00000000_80000000;
        #1;
        chk_eq("lb_wstrb", 64'(dmem_bus.dmem_wstrb), 64'h0);
        chk_eq("lb_we", 64'(dmem_bus.dmem_we), 64'h0);
        chk_eq("lb_addr", dmem_bus.dmem_addr, 64'h1000);
        tick();
        chk_eq("lb_rdata_MEM", dm_rdata_MEM, 64'hFFFFFFFFFFFFFF80);
        chk_eq("lb_rf_wr_en_MEM", 64'(rf_wr_en_MEM), 64'h1);
        chk_eq("lb_rd_MEM", 64'(rd_MEM), 64'd5);
        chk_eq("lb_sel_MEM", 64'(rf_wr_sel_MEM), 64'd1);
        set_op(64'h10C, 1'b1, 2'd1, 64'h1003, 3'd2, 3'd0, 64'h0, 5'd5);
        tick();
        chk_eq("lbu_rdata_MEM", dm_rdata_MEM, 64'h80);

        // LW with three wait cycles
        set_op(64'h110, 1'b1, 2'd1, 64'h1004, 3'd5, 3'd0, 64'h0, 5'd7);
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_eq($sformatf("lw_stall_req_%0d", i), 64'(stall_req), 64'h1);
            chk_eq($sformatf("lw_valid_%0d", i), 64'(dmem_bus.dmem_valid), 64'h1);
            tick();
            chk_eq($sformatf("lw_bubble_wr_en_%0d", i), 64'(rf_wr_en_MEM), 64'h0);
            chk_eq($sformatf("lw_bubble_rd_%0d", i), 64'(rd_MEM), 64'h0);
        end
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 64'h87654321_00000000;
        #1;
        chk_eq("lw_ready_stall_req", 64'(stall_req), 64'h0);
        tick();
        chk_eq("lw_rdata_MEM", dm_rdata_MEM, 64'hFFFFFFFF87654321);
        chk_eq("lw_rd_MEM", 64'(rd_MEM), 64'd7);
        chk_eq("lw_pc_MEM", pc_MEM, 64'h110);

        // SH at offset 6, then misaligned LH
        set_op(64'h114, 1'b0, 2'd0, 64'h1006, 3'd0, 3'd2, 64'hBEEF, 5'd0);
        dmem_bus.dmem_rdata = '0;
        #1;
        chk_eq("sh_wstrb", 64'(dmem_bus.dmem_wstrb), 64'hC0);
        chk_eq("sh_wdata", dmem_bus.dmem_wdata, 64'hBEEFBEEFBEEFBEEF);
        tick();
        chk_eq("sh_writes", 64'(wr_cnt), 64'd2);
        set_op(64'h118, 1'b1, 2'd1, 64'h1005, 3'd3, 3'd0, 64'h0, 5'd9);
        dmem_bus.dmem_ready = 1'b0;
        #1;
        chk_eq("lh_mis_valid", 64'(dmem_bus.dmem_valid), 64'h0);
        chk_eq("lh_mis_stall_req", 64'(stall_req), 64'h0);
        tick();
        chk_eq("lh_misalign_MEM", 64'(misalign_MEM), 64'h1);
        chk_eq("lh_rf_wr_en_MEM", 64'(rf_wr_en_MEM), 64'h0);
        chk_eq("lh_rdata_MEM", dm_rdata_MEM, 64'h0);
        chk_eq("lh_pc_MEM", pc_MEM, 64'h118);

        // SW completing under external stall
        set_op(64'h11C, 1'b0, 2'd0, 64'h1008, 3'd0, 3'd3, 64'hCAFEF00D12345678, 5'd0);
        stall = 1'b1;
        dmem_bus.dmem_ready = 1'b1;
        #1;
        chk_eq("sw_valid", 64'(dmem_bus.dmem_valid), 64'h1);
        chk_eq("sw_wstrb", 64'(dmem_bus.dmem_wstrb), 64'h0F);
        chk_eq("sw_wdata", dmem_bus.dmem_wdata, 64'h1234567812345678);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk_eq($sformatf("sw_hold_valid_%0d", i), 64'(dmem_bus.dmem_valid), 64'h0);
            chk_eq($sformatf("sw_hold_stall_req_%0d", i), 64'(stall_req), 64'h0);
            chk_eq($sformatf("sw_hold_pc_MEM_%0d", i), pc_MEM, 64'h118);
            tick();
        end
        stall = 1'b0;
        #1;
        chk_eq("sw_release_valid", 64'(dmem_bus.dmem_valid), 64'h0);
        tick();
        chk_eq("sw_pc_MEM", pc_MEM, 64'h11C);
        chk_eq("sw_alu_MEM", alu_result_MEM, 64'h1008);
        chk_eq("sw_misalign_MEM", 64'(misalign_MEM), 64'h0);
        chk_eq("sw_writes", 64'(wr_cnt), 64'd3);

        // LD stuck in WAIT, then asynchronous reset
        set_op(64'h120, 1'b1, 2'd1, 64'h2000, 3'd7, 3'd0, 64'h0, 5'd3);
        stall = 1'b1;
        dmem_bus.dmem_ready = 1'b0;
        tick();
        chk_eq("ld_wait_valid", 64'(dmem_bus.dmem_valid), 64'h1);
        chk_eq("ld_wait_stall_req", 64'(stall_req), 64'h1);
        chk_eq("ld_wait_pc_MEM", pc_MEM, 64'h11C);
        #2;
        reset = 1'b0;
        #1;
        chk_eq("arst_valid", 64'(dmem_bus.dmem_valid), 64'h0);
        chk_eq("arst_stall_req", 64'(stall_req), 64'h0);
        chk_eq("arst_pc_MEM", pc_MEM, 64'h0);
        chk_eq("arst_alu_MEM", alu_result_MEM, 64'h0);
        tick();
        reset = 1'b1;
        stall = 1'b0;
        set_op(64'h200, 1'b1, 2'd0, 64'h42, 3'd0, 3'd0, 64'h0, 5'd4);
        #1;
        chk_eq("post_rst_valid", 64'(dmem_bus.dmem_valid), 64'h0);
        tick();
        chk_eq("post_rst_alu_MEM", alu_result_MEM, 64'h42);
        chk_eq("post_rst_rd_MEM", 64'(rd_MEM), 64'd4);
        chk_eq("post_rst_writes", 64'(wr_cnt), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
